// File: rtl/i2c_slave_mem_responder.sv
//------------------------------------------------------------------------------
// Module  : i2c_slave_mem_responder
// Brief   : I2C slave that answers address/write/read transfers from a byte array.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module i2c_slave_mem_responder #(
    parameter int unsigned SLAVE_ADDR     = 7'h22,
    parameter int          I2C_ADDR_WIDTH = 7,
    parameter int          I2C_DATA_WIDTH = 8,
    parameter int          MEM_AW         = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      sda_o,
    output logic                      busy_o,
    output logic                      wr_stb_o,
    output logic [MEM_AW-1:0]         wr_addr_o,
    output logic [I2C_DATA_WIDTH-1:0] wr_data_o
);
    localparam int         DW        = I2C_DATA_WIDTH;
    localparam logic [3:0] BYTE_BITS = 4'(DW);
    localparam logic [3:0] LAST_TX   = 4'(DW - 1);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] ADDR     = 4'd1;
    localparam logic [3:0] ADDR_ACK = 4'd2;
    localparam logic [3:0] WR_PTR   = 4'd3;
    localparam logic [3:0] WR_ACK   = 4'd4;
    localparam logic [3:0] WR_DATA  = 4'd5;
    localparam logic [3:0] RD_DATA  = 4'd6;
    localparam logic [3:0] RD_ACK   = 4'd7;
    localparam logic [3:0] RD_WAIT  = 4'd8;

    logic              scl_meta, scl_s, scl_d;
    logic              sda_meta, sda_s, sda_d;
    logic              scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]        state, state_nxt;
    logic [3:0]        bitcnt;
    logic [DW-1:0]     shift;
    logic [DW-2:0]     tx;
    logic [MEM_AW-1:0] ptr;
    logic [DW-1:0]     mem [2**MEM_AW];
    logic              byte_done, addr_hit, rw;
    logic              sda_nxt, rx_en, tx_load, tx_shift, clr_bitcnt;
    logic              ptr_load, ptr_inc, mem_wr;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scl_meta <= 1'b1;
            scl_s    <= 1'b1;
            scl_d    <= 1'b1;
            sda_meta <= 1'b1;
            sda_s    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_meta <= scl_i;
            scl_s    <= scl_meta;
            scl_d    <= scl_s;
            sda_meta <= sda_i;
            sda_s    <= sda_meta;
            sda_d    <= sda_s;
        end
    end

    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & sda_d & ~sda_s;
    assign stop_det  = scl_s & ~sda_d & sda_s;
    assign byte_done = (bitcnt == BYTE_BITS);
    assign addr_hit  = (shift[DW-1 -: I2C_ADDR_WIDTH] == I2C_ADDR_WIDTH'(SLAVE_ADDR));
    assign rw        = shift[0];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nxt;
    end

    // STOP outranks START, and both outrank any bit-level transition.
    always_comb begin
        state_nxt = state;
        if (stop_det)       state_nxt = IDLE;
        else if (start_det) state_nxt = ADDR;
        else begin
            case (state)
                ADDR:     if (scl_fall && byte_done) state_nxt = addr_hit ? ADDR_ACK : IDLE;
                ADDR_ACK: if (scl_fall) state_nxt = rw ? RD_DATA : WR_PTR;
                WR_PTR:   if (scl_fall && byte_done) state_nxt = WR_ACK;
                WR_ACK:   if (scl_fall) state_nxt = WR_DATA;
                WR_DATA:  if (scl_fall && byte_done) state_nxt = WR_ACK;
                RD_DATA:  if (scl_fall && bitcnt == LAST_TX) state_nxt = RD_ACK;
                RD_ACK: begin
                    if (scl_rise && sda_s) state_nxt = RD_WAIT;
                    else if (scl_fall)     state_nxt = RD_DATA;
                end
                default:  state_nxt = state;
            endcase
        end
    end

    always_comb begin
        sda_nxt    = sda_o;
        rx_en      = 1'b0;
        tx_load    = 1'b0;
        tx_shift   = 1'b0;
        clr_bitcnt = 1'b0;
        ptr_load   = 1'b0;
        ptr_inc    = 1'b0;
        mem_wr     = 1'b0;
        if (start_det || stop_det) begin
            sda_nxt = 1'b1;
        end else begin
            case (state)
                ADDR: begin
                    rx_en = scl_rise && !byte_done;
                    if (scl_fall && byte_done) sda_nxt = ~addr_hit;
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        clr_bitcnt = 1'b1;
                        tx_load    = rw;
                        sda_nxt    = rw ? mem[ptr][DW-1] : 1'b1;
                    end
                end
                WR_PTR: begin
                    rx_en = scl_rise && !byte_done;
                    if (scl_fall && byte_done) begin
                        sda_nxt  = 1'b0;
                        ptr_load = 1'b1;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        sda_nxt    = 1'b1;
                        clr_bitcnt = 1'b1;
                    end
                end
                WR_DATA: begin
                    rx_en = scl_rise && !byte_done;
                    if (scl_fall && byte_done) begin
                        sda_nxt = 1'b0;
                        mem_wr  = 1'b1;
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        tx_shift = 1'b1;
                        sda_nxt  = (bitcnt == LAST_TX) ? 1'b1 : tx[DW-2];
                    end
                end
                RD_ACK: begin
                    // A fall here always follows an ACKed rise; a NACK has already left.
                    ptr_inc = scl_rise;
                    if (scl_fall) begin
                        clr_bitcnt = 1'b1;
                        tx_load    = 1'b1;
                        sda_nxt    = mem[ptr][DW-1];
                    end
                end
                default: sda_nxt = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sda_o     <= 1'b1;
            busy_o    <= 1'b0;
            wr_stb_o  <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            bitcnt    <= '0;
            shift     <= '0;
            tx        <= '0;
            ptr       <= '0;
            for (int i = 0; i < 2**MEM_AW; i++) mem[i] <= '0;
        end else begin
            sda_o    <= sda_nxt;
            wr_stb_o <= 1'b0;
            if (stop_det)       busy_o <= 1'b0;
            else if (start_det) busy_o <= 1'b1;

            if (start_det || clr_bitcnt)  bitcnt <= '0;
            else if (rx_en || tx_shift)   bitcnt <= bitcnt + 4'd1;

            if (rx_en) shift <= {shift[DW-2:0], sda_s};

            if (tx_load)       tx <= mem[ptr][DW-2:0];
            else if (tx_shift) tx <= {tx[DW-3:0], 1'b0};

            if (ptr_load)               ptr <= shift[MEM_AW-1:0];
            else if (ptr_inc || mem_wr) ptr <= ptr + 1'b1;

            if (mem_wr) begin
                mem[ptr]  <= shift;
                wr_stb_o  <= 1'b1;
                wr_addr_o <= ptr;
                wr_data_o <= shift;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_mem_responder.sv
//------------------------------------------------------------------------------
// Module  : tb_i2c_slave_mem_responder
// Brief   : Bus-level I2C master with a byte-array reference model for the slave.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_slave_mem_responder;
    localparam int         T   = 50;
    localparam logic [6:0] SLV = 7'h22;

    logic       clk = 1'b0;
    logic       rst_n, scl, m_sda;
    logic       sda_o, busy, wr_stb;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       sda_bus;
    assign sda_bus = m_sda & sda_o;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mdl_mem [16];
    int          mdl_ptr = 0;
    logic [11:0] expq[$];
    logic [11:0] obsq[$];
    int          obs_seen = 0;
    logic        watch = 1'b0;
    int          viol = 0;

    i2c_slave_mem_responder dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .scl_i    (scl),
        .sda_i    (sda_bus),
        .sda_o    (sda_o),
        .busy_o   (busy),
        .wr_stb_o (wr_stb),
        .wr_addr_o(wr_addr),
        .wr_data_o(wr_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_stb === 1'b1) obsq.push_back({wr_addr, wr_data});
        if (watch && sda_o !== 1'b1) viol++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- bus master ----------------
    task automatic bit_write(input logic b);
        #T m_sda = b;
        #T scl = 1'b1;
        #(2*T) scl = 1'b0;
    endtask

    task automatic bit_read(output logic b);
        m_sda = 1'b1;
        #(2*T) scl = 1'b1;
        #T b = sda_bus;
        #T scl = 1'b0;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        #T scl = 1'b1;
        #T m_sda = 1'b0;
        #T scl = 1'b0;
    endtask

    task automatic i2c_stop();
        #T m_sda = 1'b0;
        #T scl = 1'b1;
        #T m_sda = 1'b1;
        #(2*T);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) bit_write(b[i]);
        bit_read(ack);
    endtask

    task automatic read_byte(output logic [7:0] b, input logic nack);
        for (int i = 7; i >= 0; i--) bit_read(b[i]);
        bit_write(nack);
    endtask

    task automatic xfer_write(input logic [7:0] q[$], input logic with_stop, output int nacks);
        logic ack;
        nacks = 0;
        i2c_start();
        foreach (q[i]) begin
            write_byte(q[i], ack);
            if (ack !== 1'b0) nacks++;
        end
        if (with_stop) i2c_stop();
    endtask

    task automatic xfer_read(input int n, output logic [7:0] got[$]);
        logic [7:0] v;
        got.delete();
        for (int i = 0; i < n; i++) begin
            read_byte(v, (i == n - 1));
            got.push_back(v);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_write(input logic [7:0] q[$]);
        mdl_ptr = int'(q[0]) % 16;
        for (int i = 1; i < q.size(); i++) begin
            mdl_mem[mdl_ptr] = q[i];
            expq.push_back({4'(mdl_ptr), q[i]});
            mdl_ptr = (mdl_ptr + 1) % 16;
        end
    endtask

    task automatic model_read(output logic [7:0] v);
        v = mdl_mem[mdl_ptr];
        mdl_ptr = (mdl_ptr + 1) % 16;
    endtask

    task automatic model_reset();
        foreach (mdl_mem[i]) mdl_mem[i] = 8'h00;
        mdl_ptr = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #(2*T);
        checks++; if (sda_o !== 1'b1)   begin errors++; $display("FAIL reset_sda_o got %b want 1", sda_o); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (wr_stb !== 1'b0)  begin errors++; $display("FAIL reset_wr_stb got %b want 0", wr_stb); end
        checks++; if (wr_addr !== 4'h0) begin errors++; $display("FAIL reset_wr_addr got %h want 0", wr_addr); end
        checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got %h want 00", wr_data); end
        rst_n = 1'b1;
        #(2*T);
        checks++; if (sda_o !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle got sda_o=%b busy=%b want 1/0", sda_o, busy); end
    endtask

    task automatic test_write();
        logic [7:0] q[$];
        int nk;
        q = '{8'h44, 8'h03, 8'hA5, 8'h5A};
        xfer_write(q, 1'b0, nk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy got %b want 1", busy); end
        i2c_stop();
        checks++; if (nk !== 0) begin errors++; $display("FAIL write_acks got %0d nacks want 0", nk); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_end got %b want 0", busy); end
        void'(q.pop_front());
        model_write(q);
        checks++;
        if (obsq.size() - obs_seen != expq.size()) begin
            errors++; $display("FAIL write_strobe_count got %0d want %0d", obsq.size() - obs_seen, expq.size());
        end else foreach (expq[i]) begin
            checks++;
            if (obsq[obs_seen+i] !== expq[i]) begin errors++; $display("FAIL write_strobe[%0d] got %h want %h", i, obsq[obs_seen+i], expq[i]); end
        end
        obs_seen = obsq.size(); expq.delete();
    endtask

    task automatic test_read();
        logic [7:0] got[$];
        logic [7:0] e;
        int nk, v0;
        xfer_write('{8'h44, 8'h03}, 1'b0, nk);
        model_write('{8'h03});
        checks++; if (nk !== 0) begin errors++; $display("FAIL read_ptr_acks got %0d nacks want 0", nk); end
        xfer_write('{8'h45}, 1'b0, nk);
        checks++; if (nk !== 0) begin errors++; $display("FAIL read_addr_ack got %0d nacks want 0", nk); end
        xfer_read(2, got);
        foreach (got[i]) begin
            model_read(e);
            checks++; if (got[i] !== e) begin errors++; $display("FAIL read_data[%0d] got %h want %h", i, got[i], e); end
        end
        v0 = viol; watch = 1'b1;
        for (int i = 0; i < 9; i++) bit_write(1'b1);
        i2c_stop();
        watch = 1'b0;
        checks++; if (viol != v0) begin errors++; $display("FAIL read_release got %0d low cycles want 0", viol - v0); end
    endtask

    task automatic test_miss();
        int nk, v0;
        v0 = viol; watch = 1'b1;
        xfer_write('{8'h20, 8'h5C, 8'h00}, 1'b1, nk);
        watch = 1'b0;
        checks++; if (nk !== 3) begin errors++; $display("FAIL miss_nacks got %0d want 3", nk); end
        checks++; if (viol != v0) begin errors++; $display("FAIL miss_release got %0d low cycles want 0", viol - v0); end
        checks++; if (obsq.size() != obs_seen) begin errors++; $display("FAIL miss_strobes got %0d want 0", obsq.size() - obs_seen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL miss_busy_end got %b want 0", busy); end
        obs_seen = obsq.size();
    endtask

    task automatic test_wrap();
        logic [7:0] got[$];
        logic [7:0] e;
        int nk;
        xfer_write('{8'h44, 8'h0F, 8'h11, 8'h22}, 1'b1, nk);
        model_write('{8'h0F, 8'h11, 8'h22});
        checks++; if (nk !== 0) begin errors++; $display("FAIL wrap_acks got %0d nacks want 0", nk); end
        checks++;
        if (obsq.size() - obs_seen != expq.size()) begin
            errors++; $display("FAIL wrap_strobe_count got %0d want %0d", obsq.size() - obs_seen, expq.size());
        end else foreach (expq[i]) begin
            checks++;
            if (obsq[obs_seen+i] !== expq[i]) begin errors++; $display("FAIL wrap_strobe[%0d] got %h want %h", i, obsq[obs_seen+i], expq[i]); end
        end
        obs_seen = obsq.size(); expq.delete();
        xfer_write('{8'h44, 8'h0F}, 1'b0, nk);
        model_write('{8'h0F});
        xfer_write('{8'h45}, 1'b0, nk);
        checks++; if (nk !== 0) begin errors++; $display("FAIL wrap_read_ack got %0d nacks want 0", nk); end
        xfer_read(2, got);
        i2c_stop();
        foreach (got[i]) begin
            model_read(e);
            checks++; if (got[i] !== e) begin errors++; $display("FAIL wrap_read[%0d] got %h want %h", i, got[i], e); end
        end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic [7:0] got[$];
        logic [7:0] e, p;
        logic [6:0] a;
        int nk, n;
        for (int it = 0; it < 12; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    q = '{8'h44};
                    q.push_back(8'($urandom));
                    n = $urandom_range(0, 6);
                    repeat (n) q.push_back(8'($urandom));
                    xfer_write(q, 1'b1, nk);
                    checks++; if (nk !== 0) begin errors++; $display("FAIL rnd_write_acks it %0d got %0d nacks want 0", it, nk); end
                    void'(q.pop_front());
                    model_write(q);
                    checks++;
                    if (obsq.size() - obs_seen != expq.size()) begin
                        errors++; $display("FAIL rnd_strobe_count it %0d got %0d want %0d", it, obsq.size() - obs_seen, expq.size());
                    end else foreach (expq[i]) begin
                        checks++;
                        if (obsq[obs_seen+i] !== expq[i]) begin errors++; $display("FAIL rnd_strobe it %0d [%0d] got %h want %h", it, i, obsq[obs_seen+i], expq[i]); end
                    end
                    obs_seen = obsq.size(); expq.delete();
                end
                1: begin
                    if ($urandom_range(0, 1) == 1) begin
                        p = 8'($urandom);
                        xfer_write('{8'h44, p}, 1'b0, nk);
                        model_write('{p});
                    end
                    xfer_write('{8'h45}, 1'b0, nk);
                    checks++; if (nk !== 0) begin errors++; $display("FAIL rnd_read_ack it %0d got %0d nacks want 0", it, nk); end
                    xfer_read($urandom_range(1, 6), got);
                    i2c_stop();
                    foreach (got[i]) begin
                        model_read(e);
                        checks++; if (got[i] !== e) begin errors++; $display("FAIL rnd_read it %0d [%0d] got %h want %h", it, i, got[i], e); end
                    end
                end
                default: begin
                    a = 7'($urandom);
                    if (a == SLV) a = a ^ 7'h01;
                    xfer_write('{{a, 1'($urandom)}, 8'($urandom)}, 1'b1, nk);
                    checks++; if (nk !== 2) begin errors++; $display("FAIL rnd_miss it %0d addr %h got %0d nacks want 2", it, a, nk); end
                    checks++; if (obsq.size() != obs_seen) begin errors++; $display("FAIL rnd_miss_strobes it %0d got %0d want 0", it, obsq.size() - obs_seen); end
                    obs_seen = obsq.size();
                end
            endcase
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] got[$];
        logic [7:0] e;
        int nk;
        xfer_write('{8'h44, 8'h05, 8'h00}, 1'b1, nk);
        model_write('{8'h05, 8'h00});
        checks++; if (nk !== 0) begin errors++; $display("FAIL rmr_write_acks got %0d nacks want 0", nk); end
        checks++;
        if (obsq.size() - obs_seen != expq.size()) begin
            errors++; $display("FAIL rmr_strobe_count got %0d want %0d", obsq.size() - obs_seen, expq.size());
        end else foreach (expq[i]) begin
            checks++;
            if (obsq[obs_seen+i] !== expq[i]) begin errors++; $display("FAIL rmr_strobe[%0d] got %h want %h", i, obsq[obs_seen+i], expq[i]); end
        end
        obs_seen = obsq.size(); expq.delete();
        xfer_write('{8'h44, 8'h05}, 1'b0, nk);
        xfer_write('{8'h45}, 1'b0, nk);
        #T;
        checks++; if (sda_o !== 1'b0) begin errors++; $display("FAIL rmr_driving got %b want 0", sda_o); end
        rst_n = 1'b0;
        #1;
        checks++; if (sda_o !== 1'b1) begin errors++; $display("FAIL rmr_async_sda got %b want 1", sda_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmr_async_busy got %b want 0", busy); end
        #(T-1);
        scl = 1'b1; m_sda = 1'b1;
        #T rst_n = 1'b1;
        #(2*T);
        model_reset();
        xfer_write('{8'h45}, 1'b0, nk);
        checks++; if (nk !== 0) begin errors++; $display("FAIL rmr_addr_ack got %0d nacks want 0", nk); end
        xfer_read(1, got);
        i2c_stop();
        model_read(e);
        checks++; if (got[0] !== e) begin errors++; $display("FAIL rmr_read got %h want %h", got[0], e); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic [7:0] got[$];
        logic [7:0] e;
        int nk;
        q = '{8'h44, 8'h00};
        repeat (32) q.push_back(8'($urandom));
        xfer_write(q, 1'b1, nk);
        checks++; if (nk !== 0) begin errors++; $display("FAIL b2b_write_acks got %0d nacks want 0", nk); end
        void'(q.pop_front());
        model_write(q);
        checks++;
        if (obsq.size() - obs_seen != expq.size()) begin
            errors++; $display("FAIL b2b_strobe_count got %0d want %0d", obsq.size() - obs_seen, expq.size());
        end else foreach (expq[i]) begin
            checks++;
            if (obsq[obs_seen+i] !== expq[i]) begin errors++; $display("FAIL b2b_strobe[%0d] got %h want %h", i, obsq[obs_seen+i], expq[i]); end
        end
        obs_seen = obsq.size(); expq.delete();
        xfer_write('{8'h44, 8'h00}, 1'b0, nk);
        model_write('{8'h00});
        xfer_write('{8'h45}, 1'b0, nk);
        checks++; if (nk !== 0) begin errors++; $display("FAIL b2b_read_ack got %0d nacks want 0", nk); end
        xfer_read(32, got);
        i2c_stop();
        foreach (got[i]) begin
            model_read(e);
            checks++; if (got[i] !== e) begin errors++; $display("FAIL b2b_read[%0d] got %h want %h", i, got[i], e); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        scl   = 1'b1;
        m_sda = 1'b1;
        model_reset();
        test_reset();
        test_write();
        test_read();
        test_miss();
        test_wrap();
        test_random();
        test_reset_mid_read();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
